// File: rtl/logic_capture_if.sv
// rtl/logic_capture_if.sv - output word stream bundle for logic_capture
//
// Carries the first-word-fall-through sample stream towards the USB
// slave-FIFO writer.
//   out_data  [15:0] head sample word, zero-extended probe sample
//   out_valid        buffer holds at least one word
//   out_ready        consumer takes out_data in this cycle
// master: capture engine side; slave: consumer side.
interface logic_capture_if;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready;

  modport master (
    output out_data,
    output out_valid,
    input  out_ready
  );

  modport slave (
    input  out_data,
    input  out_valid,
    output out_ready
  );
endinterface

// File: rtl/logic_capture.sv
// rtl/logic_capture.sv - logic-analyser capture engine with pattern trigger and sample FIFO
//
// Samples the probe bus on a programmable strobe, waits for a masked pattern
// (when LOGIC_CAPTURE_TRIG_EN is defined), then stores cap_len samples in a
// FIFO that is drained through out_if.
// Optional feature macro: LOGIC_CAPTURE_TRIG_EN (trigger comparator and ARMED
// state). Without it, arm goes straight to capture and trig_* are ignored.
// Ports:
//   clk, rst        capture clock, asynchronous active-low reset
//   din             probe inputs (asynchronous, synchronised internally)
//   arm, abort      single-cycle run start / run stop pulses
//   div             strobe period minus one
//   cap_len         samples per run, 0 = until abort
//   trig_mask/value masked trigger pattern
//   out_if          sample word stream (master)
//   busy, triggered, done, overflow  run status
module logic_capture #(
  parameter int CH_WIDTH   = 16,
  parameter int FIFO_DEPTH = 512,
  parameter int DIV_WIDTH  = 16,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [CH_WIDTH-1:0]  din,
  input  logic                 arm,
  input  logic                 abort,
  input  logic [DIV_WIDTH-1:0] div,
  input  logic [CNT_WIDTH-1:0] cap_len,
  input  logic [CH_WIDTH-1:0]  trig_mask,
  input  logic [CH_WIDTH-1:0]  trig_value,
  logic_capture_if.master      out_if,
  output logic                 busy,
  output logic                 triggered,
  output logic                 done,
  output logic                 overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH_L = FIFO_DEPTH[AW:0];

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_CAPTURE = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [CH_WIDTH-1:0]  r_sync1;
  logic [CH_WIDTH-1:0]  r_s;
  logic [DIV_WIDTH-1:0] r_div_cnt;
  logic [CNT_WIDTH-1:0] r_smp_cnt;
  logic                 r_triggered;
  logic                 r_done;
  logic                 r_overflow;

  logic [CH_WIDTH-1:0]  r_mem [FIFO_DEPTH];
  logic [AW:0]          r_wr_ptr;
  logic [AW:0]          r_rd_ptr;

  logic                 w_strobe;
  logic                 w_arm_go;
  logic [CNT_WIDTH-1:0] w_cnt_inc;
  logic                 w_last;
  logic                 w_push;
  logic                 w_set_trig;
  logic                 w_set_done;
  logic                 w_clear;
  logic [AW:0]          w_level;
  logic                 w_empty;
  logic                 w_full;
  logic                 w_pop;
  logic                 w_fifo_wr;
  logic [15:0]          w_head;

  // Two-flop synchroniser for the asynchronous probe pins.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync1 <= '0;
      r_s     <= '0;
    end else begin
      r_sync1 <= din;
      r_s     <= r_sync1;
    end
  end

  // Strobe on wrap; >= keeps the counter bounded if div shrinks mid-count.
  assign w_strobe = (r_div_cnt >= div);
  assign w_arm_go = arm && (r_state == ST_IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_div_cnt <= '0;
    end else if (w_arm_go || w_strobe) begin
      r_div_cnt <= '0;
    end else begin
      r_div_cnt <= r_div_cnt + DIV_WIDTH'(1);
    end
  end

`ifdef LOGIC_CAPTURE_TRIG_EN
  logic w_trig_hit;
  assign w_trig_hit = (((r_s ^ trig_value) & trig_mask) == '0);
`else
  logic w_trig_unused;
  assign w_trig_unused = ^{trig_mask, trig_value};
`endif

  // Dropped samples still advance the count, so the run length is in strobes.
  assign w_cnt_inc = r_smp_cnt + CNT_WIDTH'(1);
  assign w_last    = (cap_len != '0) && (w_cnt_inc == cap_len);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_push      = 1'b0;
    w_set_trig  = 1'b0;
    w_set_done  = 1'b0;
    w_clear     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (arm) begin
          w_clear = 1'b1;
`ifdef LOGIC_CAPTURE_TRIG_EN
          w_state_nxt = ST_ARMED;
`else
          w_state_nxt = ST_CAPTURE;
`endif
        end
      end
`ifdef LOGIC_CAPTURE_TRIG_EN
      ST_ARMED: begin
        if (abort) begin
          w_set_done  = 1'b1;
          w_state_nxt = ST_IDLE;
        end else if (w_strobe && w_trig_hit) begin
          // The triggering sample is the first one stored.
          w_set_trig  = 1'b1;
          w_push      = 1'b1;
          w_state_nxt = ST_CAPTURE;
          if (w_last) begin
            w_set_done  = 1'b1;
            w_state_nxt = ST_IDLE;
          end
        end
      end
`endif
      ST_CAPTURE: begin
        if (abort) begin
          w_set_done  = 1'b1;
          w_state_nxt = ST_IDLE;
        end else if (w_strobe) begin
          // Re-asserting triggered is a no-op once set; without the
          // comparator this marks the first strobe of the run.
          w_set_trig = 1'b1;
          w_push     = 1'b1;
          if (w_last) begin
            w_set_done  = 1'b1;
            w_state_nxt = ST_IDLE;
          end
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_smp_cnt   <= '0;
      r_triggered <= 1'b0;
      r_done      <= 1'b0;
      r_overflow  <= 1'b0;
    end else if (w_clear) begin
      r_smp_cnt   <= '0;
      r_triggered <= 1'b0;
      r_done      <= 1'b0;
      r_overflow  <= 1'b0;
    end else begin
      if (w_push) begin
        r_smp_cnt <= w_cnt_inc;
      end
      if (w_set_trig) begin
        r_triggered <= 1'b1;
      end
      if (w_set_done) begin
        r_done <= 1'b1;
      end
      if (w_push && !w_fifo_wr) begin
        r_overflow <= 1'b1;
      end
    end
  end

  // Sample FIFO: pointers carry one extra bit to tell full from empty.
  assign w_level   = r_wr_ptr - r_rd_ptr;
  assign w_empty   = (r_wr_ptr == r_rd_ptr);
  assign w_full    = (w_level == DEPTH_L);
  assign w_pop     = !w_empty && out_if.out_ready;
  // A pop frees the head slot in the same cycle, so a full FIFO still accepts.
  assign w_fifo_wr = w_push && (!w_full || w_pop);

  always_ff @(posedge clk) begin
    if (w_fifo_wr) begin
      r_mem[r_wr_ptr[AW-1:0]] <= r_s;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_fifo_wr) begin
        r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
      end
    end
  end

  // Head word reads as zero while empty so stale memory never shows.
  always_comb begin
    w_head = '0;
    if (!w_empty) begin
      w_head[CH_WIDTH-1:0] = r_mem[r_rd_ptr[AW-1:0]];
    end
  end

  assign out_if.out_data  = w_head;
  assign out_if.out_valid = !w_empty;
  assign busy             = (r_state != ST_IDLE);
  assign triggered        = r_triggered;
  assign done             = r_done;
  assign overflow         = r_overflow;

endmodule

// File: tb/tb_logic_capture.sv
// tb/tb_logic_capture.sv - randomized self-checking bench for logic_capture
`timescale 1ns/1ps
module tb_logic_capture;
  localparam int CH_WIDTH   = 16;
  localparam int FIFO_DEPTH = 512;
  localparam int DIV_WIDTH  = 16;
  localparam int CNT_WIDTH  = 32;
  localparam int HN         = 4096;
`ifdef LOGIC_CAPTURE_TRIG_EN
  localparam bit TRIG_EN = 1'b1;
`else
  localparam bit TRIG_EN = 1'b0;
`endif

  logic                 clk = 1'b0;
  logic                 rst;
  logic [CH_WIDTH-1:0]  din;
  logic                 arm;
  logic                 abort;
  logic [DIV_WIDTH-1:0] div;
  logic [CNT_WIDTH-1:0] cap_len;
  logic [CH_WIDTH-1:0]  trig_mask;
  logic [CH_WIDTH-1:0]  trig_value;
  logic                 busy;
  logic                 triggered;
  logic                 done;
  logic                 overflow;

  logic_capture_if u_if();

  logic_capture #(
    .CH_WIDTH(CH_WIDTH), .FIFO_DEPTH(FIFO_DEPTH),
    .DIV_WIDTH(DIV_WIDTH), .CNT_WIDTH(CNT_WIDTH)
  ) dut (
    .clk(clk), .rst(rst), .din(din), .arm(arm), .abort(abort),
    .div(div), .cap_len(cap_len), .trig_mask(trig_mask), .trig_value(trig_value),
    .out_if(u_if), .busy(busy), .triggered(triggered), .done(done), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [15:0] hist [HN];
  logic [15:0] got_q [$];
  logic [15:0] exp_q [$];
  int          n_vec = 0;
  int          n_err = 0;
  int          din_mode = 0;
  logic [15:0] din_seq = '0;
  bit          rnd_ready = 1'b0;

  always @(negedge clk)
    if (rst && u_if.out_valid && u_if.out_ready) got_q.push_back(u_if.out_data);

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time expired, expected completion");
    $fatal(1);
  end

  task automatic tick();
    logic [15:0] r;
    @(posedge clk);
    #1;
    r = 16'($urandom);
    case (din_mode)
      1: begin din = din_seq; din_seq = din_seq + 16'd1; end
      2: begin din = {r[15:3], din_seq[2:0]}; din_seq = din_seq + 16'd1; end
      default: din = r;
    endcase
    hist[cyc % HN] = din;
    if (rnd_ready) u_if.out_ready = 1'($urandom_range(0, 1));
  endtask

  // Reference: the stored stream is the synchronised probe value (din two
  // cycles earlier) at every strobe, strobes falling at ta+1+div+k*(div+1),
  // starting at the first strobe that matches the trigger pattern.
  task automatic build_exp(input int ta, input int dv, input int want,
                           input logic [15:0] tm, input logic [15:0] tv);
    int          sc;
    logic [15:0] v;
    bit          trg;
    trg = !TRIG_EN;
    exp_q.delete();
    for (int k = 0; exp_q.size() < want; k++) begin
      sc = ta + 1 + dv + k * (dv + 1);
      if (sc >= cyc) break;
      v = hist[(sc - 2) % HN];
      if (!trg && ((v ^ tv) & tm) == 16'd0) trg = 1'b1;
      if (trg) exp_q.push_back(v);
    end
  endtask

  task automatic start_run(input int dv, input int len, input logic [15:0] tm,
                           input logic [15:0] tv, output int ta);
    div = DIV_WIDTH'(dv);
    cap_len = CNT_WIDTH'(len);
    trig_mask = tm;
    trig_value = tv;
    got_q.delete();
    arm = 1'b1;
    ta = cyc;
    tick();
    arm = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (done) begin ok = 1'b1; break; end
      tick();
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; arm = 1'b0; abort = 1'b0; din = '0;
    div = '0; cap_len = '0; trig_mask = '0; trig_value = '0;
    u_if.out_ready = 1'b0;
    repeat (3) tick();
    n_vec++; if (u_if.out_data !== 16'h0) begin n_err++; $display("FAIL reset_out_data: got %h, expected 0000", u_if.out_data); end
    n_vec++; if (u_if.out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b, expected 0", u_if.out_valid); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b, expected 0", busy); end
    n_vec++; if ({triggered, done, overflow} !== 3'b000) begin n_err++; $display("FAIL reset_flags: got %b, expected 000", {triggered, done, overflow}); end
    rst = 1'b1;
    tick();
    n_vec++; if ({u_if.out_valid, busy, done} !== 3'b000) begin n_err++; $display("FAIL reset_release: got %b, expected 000", {u_if.out_valid, busy, done}); end
  endtask

  task automatic test_count();
    int ta; bit ok;
    din_mode = 1; din_seq = 16'h0000; u_if.out_ready = 1'b1;
    start_run(0, 8, 16'h0, 16'h0, ta);
    n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL count_busy_after_arm: got %b, expected 1", busy); end
    wait_done(100, ok);
    n_vec++; if (!ok) begin n_err++; $display("FAIL count_done_timeout: got done=%b, expected 1", done); end
    repeat (4) tick();
    build_exp(ta, 0, 8, 16'h0, 16'h0);
    n_vec++; if (got_q.size() != 8) begin n_err++; $display("FAIL count_len: got %0d words, expected 8", got_q.size()); end
    foreach (exp_q[i]) if (i < got_q.size()) begin
      n_vec++; if (got_q[i] !== exp_q[i]) begin n_err++; $display("FAIL count_word[%0d]: got %h, expected %h", i, got_q[i], exp_q[i]); end
    end
    n_vec++; if ({done, overflow, busy} !== 3'b100) begin n_err++; $display("FAIL count_flags: got done/ovf/busy=%b, expected 100", {done, overflow, busy}); end
  endtask

  task automatic test_div();
    int ta; int sc4;
    din_mode = 0; u_if.out_ready = 1'b1;
    start_run(3, 4, 16'h0, 16'h0, ta);
    sc4 = ta + 1 + 3 + 3 * 4;
    for (int i = 0; i < 40 && cyc < sc4; i++) tick();
    n_vec++; if ({busy, done} !== 2'b10) begin n_err++; $display("FAIL div_last_push_cycle: got busy/done=%b, expected 10", {busy, done}); end
    tick();
    n_vec++; if ({busy, done} !== 2'b01) begin n_err++; $display("FAIL div_after_last_push: got busy/done=%b, expected 01", {busy, done}); end
    repeat (4) tick();
    build_exp(ta, 3, 4, 16'h0, 16'h0);
    n_vec++; if (got_q.size() != exp_q.size()) begin n_err++; $display("FAIL div_len: got %0d words, expected %0d", got_q.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < got_q.size()) begin
      n_vec++; if (got_q[i] !== exp_q[i]) begin n_err++; $display("FAIL div_word[%0d]: got %h, expected %h", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_trigger();
    int ta; bit ok;
    din_mode = 2; din_seq = '0; u_if.out_ready = 1'b1;
    start_run(0, 6, 16'h0003, 16'h0002, ta);
    wait_done(100, ok);
    n_vec++; if (!ok) begin n_err++; $display("FAIL trig_done_timeout: got done=%b, expected 1", done); end
    repeat (4) tick();
    build_exp(ta, 0, 6, 16'h0003, 16'h0002);
    n_vec++; if (got_q.size() != exp_q.size()) begin n_err++; $display("FAIL trig_len: got %0d words, expected %0d", got_q.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < got_q.size()) begin
      n_vec++; if (got_q[i] !== exp_q[i]) begin n_err++; $display("FAIL trig_word[%0d]: got %h, expected %h", i, got_q[i], exp_q[i]); end
    end
    n_vec++; if (triggered !== 1'b1) begin n_err++; $display("FAIL trig_sticky: got %b, expected 1", triggered); end
  endtask

  task automatic test_overflow();
    int ta; bit ok;
    din_mode = 0; u_if.out_ready = 1'b0;
    start_run(0, FIFO_DEPTH + 5, 16'h0, 16'h0, ta);
    wait_done(FIFO_DEPTH + 100, ok);
    n_vec++; if (!ok) begin n_err++; $display("FAIL ovf_done_timeout: got done=%b, expected 1", done); end
    n_vec++; if ({overflow, u_if.out_valid} !== 2'b11) begin n_err++; $display("FAIL ovf_flags: got ovf/valid=%b, expected 11", {overflow, u_if.out_valid}); end
    u_if.out_ready = 1'b1;
    repeat (FIFO_DEPTH + 4) tick();
    build_exp(ta, 0, FIFO_DEPTH, 16'h0, 16'h0);
    n_vec++; if (got_q.size() != FIFO_DEPTH) begin n_err++; $display("FAIL ovf_len: got %0d words, expected %0d", got_q.size(), FIFO_DEPTH); end
    foreach (exp_q[i]) if (i < got_q.size()) begin
      n_vec++; if (got_q[i] !== exp_q[i]) begin n_err++; $display("FAIL ovf_word[%0d]: got %h, expected %h", i, got_q[i], exp_q[i]); end
    end
    n_vec++; if (u_if.out_valid !== 1'b0) begin n_err++; $display("FAIL ovf_drained: got valid=%b, expected 0", u_if.out_valid); end
  endtask

  task automatic test_back_to_back();
    int ta; bit ok;
    din_mode = 0; u_if.out_ready = 1'b0;
    start_run(0, FIFO_DEPTH + 5, 16'h0, 16'h0, ta);
    for (int i = 0; i < FIFO_DEPTH + 20 && cyc < ta + 1 + FIFO_DEPTH; i++) tick();
    u_if.out_ready = 1'b1;
    wait_done(100, ok);
    n_vec++; if (!ok) begin n_err++; $display("FAIL b2b_done_timeout: got done=%b, expected 1", done); end
    repeat (FIFO_DEPTH + 4) tick();
    build_exp(ta, 0, FIFO_DEPTH + 5, 16'h0, 16'h0);
    n_vec++; if (got_q.size() != FIFO_DEPTH + 5) begin n_err++; $display("FAIL b2b_len: got %0d words, expected %0d", got_q.size(), FIFO_DEPTH + 5); end
    foreach (exp_q[i]) if (i < got_q.size()) begin
      n_vec++; if (got_q[i] !== exp_q[i]) begin n_err++; $display("FAIL b2b_word[%0d]: got %h, expected %h", i, got_q[i], exp_q[i]); end
    end
    n_vec++; if (overflow !== 1'b0) begin n_err++; $display("FAIL b2b_overflow: got %b, expected 0", overflow); end
  endtask

  task automatic test_abort();
    int ta; bit ok;
    din_mode = 0; u_if.out_ready = 1'b1;
    start_run(0, 0, 16'h0, 16'h0, ta);
    for (int i = 0; i < 40 && cyc < ta + 21; i++) tick();
    abort = 1'b1;   // coincides with the 21st strobe, which must be discarded
    tick();
    abort = 1'b0;
    n_vec++; if ({done, busy} !== 2'b10) begin n_err++; $display("FAIL abort_flags: got done/busy=%b, expected 10", {done, busy}); end
    repeat (4) tick();
    build_exp(ta, 0, 20, 16'h0, 16'h0);
    n_vec++; if (got_q.size() != 20) begin n_err++; $display("FAIL abort_len: got %0d words, expected 20", got_q.size()); end
    foreach (exp_q[i]) if (i < got_q.size()) begin
      n_vec++; if (got_q[i] !== exp_q[i]) begin n_err++; $display("FAIL abort_word[%0d]: got %h, expected %h", i, got_q[i], exp_q[i]); end
    end
    start_run(1, 3, 16'h0, 16'h0, ta);
    n_vec++; if ({done, triggered, overflow, busy} !== 4'b0001) begin n_err++; $display("FAIL rearm_flags: got done/trig/ovf/busy=%b, expected 0001", {done, triggered, overflow, busy}); end
    wait_done(100, ok);
    n_vec++; if (!ok) begin n_err++; $display("FAIL rearm_done_timeout: got done=%b, expected 1", done); end
    repeat (4) tick();
    build_exp(ta, 1, 3, 16'h0, 16'h0);
    n_vec++; if (got_q.size() != 3) begin n_err++; $display("FAIL rearm_len: got %0d words, expected 3", got_q.size()); end
    foreach (exp_q[i]) if (i < got_q.size()) begin
      n_vec++; if (got_q[i] !== exp_q[i]) begin n_err++; $display("FAIL rearm_word[%0d]: got %h, expected %h", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_random();
    int ta; int dv; int len; bit ok; logic [15:0] tm; logic [15:0] tv;
    din_mode = 0;
    for (int it = 0; it < 5; it++) begin
      dv  = $urandom_range(0, 3);
      len = $urandom_range(1, 12);
      tm  = 16'd1 << $urandom_range(0, 15);
      tv  = 16'($urandom);
      rnd_ready = 1'b1;
      start_run(dv, len, tm, tv, ta);
      wait_done(1500, ok);
      rnd_ready = 1'b0; u_if.out_ready = 1'b1;
      n_vec++; if (!ok) begin n_err++; $display("FAIL rand%0d_done_timeout: got done=%b, expected 1", it, done); end
      repeat (20) tick();
      build_exp(ta, dv, len, tm, tv);
      n_vec++; if (got_q.size() != len) begin n_err++; $display("FAIL rand%0d_len: got %0d words, expected %0d", it, got_q.size(), len); end
      foreach (exp_q[i]) if (i < got_q.size()) begin
        n_vec++; if (got_q[i] !== exp_q[i]) begin n_err++; $display("FAIL rand%0d_word[%0d]: got %h, expected %h", it, i, got_q[i], exp_q[i]); end
      end
    end
  endtask

  task automatic test_reset_mid();
    int ta;
    din_mode = 0; u_if.out_ready = 1'b0;
    start_run(0, 100, 16'h0, 16'h0, ta);
    repeat (10) tick();
    n_vec++; if ({u_if.out_valid, busy} !== 2'b11) begin n_err++; $display("FAIL rstmid_pre: got valid/busy=%b, expected 11", {u_if.out_valid, busy}); end
    #3 rst = 1'b0;
    #1;
    n_vec++; if (u_if.out_data !== 16'h0) begin n_err++; $display("FAIL rstmid_out_data: got %h, expected 0000", u_if.out_data); end
    n_vec++; if ({u_if.out_valid, busy, triggered, done, overflow} !== 5'b0) begin n_err++; $display("FAIL rstmid_async: got valid/busy/trig/done/ovf=%b, expected 00000", {u_if.out_valid, busy, triggered, done, overflow}); end
    tick();
    rst = 1'b1;
    tick();
    n_vec++; if ({u_if.out_valid, busy} !== 2'b00) begin n_err++; $display("FAIL rstmid_release: got valid/busy=%b, expected 00", {u_if.out_valid, busy}); end
  endtask

  initial begin
    test_reset();
    test_count();
    test_div();
    test_trigger();
    test_overflow();
    test_back_to_back();
    test_abort();
    test_random();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
